// File: rtl/uram_port_arbiter_pkg.sv
// uram_arb_pkg: shared types and helpers for uram_port_arbiter.
// Holds the read-latency helper, the controller state enum and the read tag.
package uram_arb_pkg;

    // Controller states; ZERO is reachable only when URAM_ARB_ZEROIZE_EN is defined.
    typedef enum logic {
        RUN  = 1'b0,
        ZERO = 1'b1
    } arb_state_e;

    // One in-flight read slot: valid marks a real read, id names its requester.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    // Read latency of the UltraRAM: address/control register, array access,
    // then NBPIPE output pipeline stages.
    function automatic int arb_lat(input int nbpipe);
        return nbpipe + 2;
    endfunction

endpackage

// File: rtl/uram_port_arbiter_if.sv
// uram_port_arbiter_if: the two requester channels of uram_port_arbiter.
// Handshake: a request transfers in a cycle where reqN_valid && reqN_ready.
// Ready may depend combinationally on valid in the same cycle, valid must not
// depend on ready, and a requester may drop valid without a transfer.
// rspN_valid is a single-cycle pulse with no backpressure; rspN_rdata is
// meaningful only while rspN_valid is high.
interface uram_port_arbiter_if #(
    parameter int AWIDTH  = 12,
    parameter int NUM_COL = 9,
    parameter int DWIDTH  = 72
);
    logic               req0_valid;
    logic               req0_ready;
    logic [NUM_COL-1:0] req0_we;
    logic [AWIDTH-1:0]  req0_addr;
    logic [DWIDTH-1:0]  req0_wdata;
    logic               rsp0_valid;
    logic [DWIDTH-1:0]  rsp0_rdata;

    logic               req1_valid;
    logic               req1_ready;
    logic [NUM_COL-1:0] req1_we;
    logic [AWIDTH-1:0]  req1_addr;
    logic [DWIDTH-1:0]  req1_wdata;
    logic               rsp1_valid;
    logic [DWIDTH-1:0]  rsp1_rdata;

    // Requester side.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/uram_rd_tag_pipe.sv
// uram_rd_tag_pipe: LAT-deep shift register of {valid, id} read tags that
// runs alongside the RAM read pipeline. Asynchronous clear drops every
// in-flight read so no response is produced for it.
module uram_rd_tag_pipe
    import uram_arb_pkg::*;
#(
    parameter int LAT = 5
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    any_valid
);
    rd_tag_t stage [LAT];

    // Advance every cycle; the RAM pipeline moves every cycle too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    // Any real read still travelling through the RAM.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) any_valid = any_valid | stage[i].valid;
    end

    assign tag_out = stage[LAT-1];

endmodule

// File: rtl/uram_port_arbiter.sv
// uram_port_arbiter: round-robin sharing of one single-port no-change
// UltraRAM between two requesters, with read tags routing each returned
// word to its issuer. Optional macro URAM_ARB_ZEROIZE_EN adds a post-reset
// ZERO pass that clears every address before requests are accepted.
module uram_port_arbiter
    import uram_arb_pkg::*;
#(
    parameter int AWIDTH  = 12,
    parameter int NUM_COL = 9,
    parameter int CWIDTH  = 8,
    parameter int DWIDTH  = 72,
    parameter int NBPIPE  = 3
) (
    input  logic                clk,
    input  logic                rst,
    uram_port_arbiter_if.slave  req_if,
    output logic                ram_mem_en,
    output logic [NUM_COL-1:0]  ram_we,
    output logic [AWIDTH-1:0]   ram_addr,
    output logic [DWIDTH-1:0]   ram_din,
    output logic                ram_regce,
    output logic                ram_rst,
    input  logic [DWIDTH-1:0]   ram_dout,
    output logic                busy,
    output arb_state_e          dbg_state
);
    localparam int LAT = arb_lat(NBPIPE);

    if (DWIDTH != NUM_COL * CWIDTH) begin : g_width_check
        $error("uram_port_arbiter: DWIDTH must equal NUM_COL*CWIDTH");
    end

`ifdef URAM_ARB_ZEROIZE_EN
    localparam arb_state_e RESET_STATE = ZERO;
    logic [AWIDTH-1:0] zero_cnt;
`else
    localparam arb_state_e RESET_STATE = RUN;
`endif

    arb_state_e         state, state_next;
    logic               accepting;
    logic               last_gnt;
    logic               gnt0, gnt1, xfer, win_id;
    logic [NUM_COL-1:0] win_we;
    logic [AWIDTH-1:0]  win_addr;
    logic [DWIDTH-1:0]  win_wdata;
    rd_tag_t            tag_in, tag_out;
    logic               tags_busy;

    // Requests are only taken in RUN and never while reset is held.
    assign accepting = (state == RUN) && !rst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_next;
    end

    // Next state: leave ZERO the cycle after the last address is written.
    always_comb begin
        state_next = state;
`ifdef URAM_ARB_ZEROIZE_EN
        if (state == ZERO && zero_cnt == '1) state_next = RUN;
`endif
    end

`ifdef URAM_ARB_ZEROIZE_EN
    // Zeroize address counter; its wrap back to zero ends the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                zero_cnt <= '0;
        else if (state == ZERO) zero_cnt <= zero_cnt + 1'b1;
    end
`endif

    // Grant: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (accepting) begin
            if (req_if.req0_valid && req_if.req1_valid) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req_if.req0_valid;
                gnt1 = req_if.req1_valid;
            end
        end
    end

    assign xfer      = gnt0 | gnt1;
    assign win_id    = gnt1;
    assign win_we    = win_id ? req_if.req1_we    : req_if.req0_we;
    assign win_addr  = win_id ? req_if.req1_addr  : req_if.req0_addr;
    assign win_wdata = win_id ? req_if.req1_wdata : req_if.req0_wdata;

    assign req_if.req0_ready = gnt0;
    assign req_if.req1_ready = gnt1;

    // Round-robin memory: moves only when a transfer actually happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_gnt <= 1'b1;
        else if (xfer) last_gnt <= win_id;
    end

    // RAM port: straight from the winning request, or from the zeroize pass.
    always_comb begin
        ram_mem_en = 1'b0;
        ram_we     = '0;
        ram_addr   = win_addr;
        ram_din    = win_wdata;
        if (xfer) begin
            ram_mem_en = 1'b1;
            ram_we     = win_we;
        end
`ifdef URAM_ARB_ZEROIZE_EN
        if (state == ZERO && !rst) begin
            ram_mem_en = 1'b1;
            ram_we     = '1;
            ram_addr   = zero_cnt;
            ram_din    = '0;
        end
`endif
    end

    assign ram_regce = 1'b1;
    assign ram_rst   = rst;

    // Writes enter the tag pipe as bubbles so their stale RAM output is dropped.
    assign tag_in.valid = xfer && (win_we == '0);
    assign tag_in.id    = win_id;

    uram_rd_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (tags_busy)
    );

    assign req_if.rsp0_valid = tag_out.valid && !tag_out.id;
    assign req_if.rsp1_valid = tag_out.valid &&  tag_out.id;
    assign req_if.rsp0_rdata = ram_dout;
    assign req_if.rsp1_rdata = ram_dout;

    assign busy      = tags_busy || (state == ZERO && !rst);
    assign dbg_state = state;

endmodule

// File: tb/tb_uram_port_arbiter.sv
// tb_uram_port_arbiter: bench for uram_port_arbiter with a behavioural
// UltraRAM model, a shadow-memory / expected-response reference model,
// a vector table, directed corner sequences and a randomized phase.
// Build with URAM_ARB_ZEROIZE_EN to exercise the zeroize pass (AWIDTH=4).
module tb_uram_port_arbiter;
    import uram_arb_pkg::*;

`ifdef URAM_ARB_ZEROIZE_EN
    localparam int AW = 4;
`else
    localparam int AW = 12;
`endif
    localparam int NC     = 9;
    localparam int CW     = 8;
    localparam int DW     = 72;
    localparam int NBPIPE = 3;
    localparam int LAT    = NBPIPE + 2;
    localparam int EW     = 32 + 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uram_port_arbiter_if #(.AWIDTH(AW), .NUM_COL(NC), .DWIDTH(DW)) bus ();

    logic              ram_mem_en;
    logic [NC-1:0]     ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_din;
    logic              ram_regce;
    logic              ram_rst;
    logic [DW-1:0]     ram_dout;
    logic              busy;
    arb_state_e        dbg_state;

    uram_port_arbiter #(
        .AWIDTH (AW), .NUM_COL (NC), .CWIDTH (CW), .DWIDTH (DW), .NBPIPE (NBPIPE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_if     (bus),
        .ram_mem_en (ram_mem_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_regce  (ram_regce),
        .ram_rst    (ram_rst),
        .ram_dout   (ram_dout),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- UltraRAM behavioural model ----------------
    function automatic logic [DW-1:0] init_word(input int a);
        return {8'(a) ^ 8'h5a, 32'(a * 32'h9E3779B1), 32'(a * 32'h85EBCA6B)};
    endfunction

    logic [DW-1:0] ram_mem  [1 << AW];
    logic [DW-1:0] ram_pipe [LAT];
    logic          ram_filled = 1'b0;

    // No-change single port: reads load the pipe, writes leave it holding.
    always @(posedge clk) begin
        if (!ram_filled) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= init_word(i);
            ram_filled <= 1'b1;
        end else if (ram_mem_en && ram_we != '0) begin
            for (int c = 0; c < NC; c++)
                if (ram_we[c]) ram_mem[ram_addr][c*CW +: CW] <= ram_din[c*CW +: CW];
        end
        ram_pipe[0] <= (ram_mem_en && ram_we == '0) ? ram_mem[ram_addr] : ram_pipe[0];
        for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_dout = ram_pipe[LAT-1];

    // ---------------- scoreboard / reference model ----------------
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc   = 0;
    int              rsp_seen = 0;
    logic            m_last = 1'b1;
    logic [EW-1:0]   exp_q [$];
    logic [DW-1:0]   shadow [int];
    logic            obs_r0, obs_r1;
    logic [DW-1:0]   last_rsp0, last_rsp1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return init_word(int'(a));
    endfunction

    function automatic logic [DW-1:0] rand_word();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int n, input logic v, input logic [NC-1:0] we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    // One clock cycle: inputs are already applied just after a negedge.
    task automatic step();
        logic          g0, g1, xf, wid, e0, e1;
        logic [NC-1:0] wwe;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, word;
        logic [EW-1:0] head;
        #1;
        g0 = bus.req0_valid && (!bus.req1_valid || m_last);
        g1 = bus.req1_valid && (!bus.req0_valid || !m_last);
        obs_r0 = bus.req0_ready;
        obs_r1 = bus.req1_ready;
        chk("rdy0", bus.req0_ready, g0);
        chk("rdy1", bus.req1_ready, g1);
        xf  = g0 | g1;
        wid = g1;
        wwe = wid ? bus.req1_we    : bus.req0_we;
        wa  = wid ? bus.req1_addr  : bus.req0_addr;
        wd  = wid ? bus.req1_wdata : bus.req0_wdata;
        chk("ram_en", ram_mem_en, xf);
        chk("ram_we", ram_we, xf ? wwe : '0);
        if (xf) begin
            chk("ram_addr", ram_addr, wa);
            chk("ram_din", ram_din, wd);
        end
        chk("busy", busy, exp_q.size() != 0);
        e0 = 1'b0; e1 = 1'b0; head = '0;
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            if (head[EW-1 -: 32] == 32'(cyc)) begin
                void'(exp_q.pop_front());
                e0 = !head[DW];
                e1 = head[DW];
            end
        end
        chk("rsp0_valid", bus.rsp0_valid, e0);
        chk("rsp1_valid", bus.rsp1_valid, e1);
        if (e0) chk("rsp0_data", bus.rsp0_rdata, head[DW-1:0]);
        if (e1) chk("rsp1_data", bus.rsp1_rdata, head[DW-1:0]);
        if (bus.rsp0_valid === 1'b1) begin last_rsp0 = bus.rsp0_rdata; rsp_seen++; end
        if (bus.rsp1_valid === 1'b1) begin last_rsp1 = bus.rsp1_rdata; rsp_seen++; end
        if (xf) begin
            if (wwe == '0) begin
                exp_q.push_back({32'(cyc + LAT), wid, shadow_rd(wa)});
            end else begin
                word = shadow_rd(wa);
                for (int c = 0; c < NC; c++)
                    if (wwe[c]) word[c*CW +: CW] = wd[c*CW +: CW];
                shadow[int'(wa)] = word;
            end
            m_last = wid;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int k);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_rdy0"}, bus.req0_ready, 1'b0);
        chk({tag, "_rdy1"}, bus.req1_ready, 1'b0);
        chk({tag, "_rsp0"}, bus.rsp0_valid, 1'b0);
        chk({tag, "_rsp1"}, bus.rsp1_valid, 1'b0);
        chk({tag, "_en"},   ram_mem_en, 1'b0);
        chk({tag, "_we"},   ram_we, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ramrst"}, ram_rst, 1'b1);
    endtask

`ifdef URAM_ARB_ZEROIZE_EN
    // Requests held high must be refused while every address is cleared.
    task automatic zeroize_run();
        set_req(0, 1'b1, '0, '0, '0);
        set_req(1, 1'b1, '0, '0, '0);
        for (int i = 0; i < (1 << AW); i++) begin
            #1;
            chk("z_rdy0", bus.req0_ready, 1'b0);
            chk("z_rdy1", bus.req1_ready, 1'b0);
            chk("z_busy", busy, 1'b1);
            chk("z_en", ram_mem_en, 1'b1);
            chk("z_we", ram_we, {NC{1'b1}});
            chk("z_addr", ram_addr, i);
            chk("z_din", ram_din, '0);
            chk("z_state", dbg_state, ZERO);
            @(negedge clk);
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        for (int a = 0; a < (1 << AW); a++) shadow[a] = '0;
    endtask
`endif

    // ---------------- vector table ----------------
    typedef struct {
        logic          v0, v1;
        logic [NC-1:0] we0, we1;
        logic [AW-1:0] a0, a1;
        logic          r0, r1;
    } vec_t;

    localparam int NTBL = 14;
    vec_t tbl [NTBL];

    function automatic vec_t mk(input logic v0, input logic v1, input logic w0, input logic w1,
                                input int a0, input int a1, input logic r0, input logic r1);
        vec_t t;
        t.v0 = v0; t.v1 = v1;
        t.we0 = w0 ? {NC{1'b1}} : '0;
        t.we1 = w1 ? {NC{1'b1}} : '0;
        t.a0 = AW'(a0); t.a1 = AW'(a1);
        t.r0 = r0; t.r1 = r1;
        return t;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int seen0;
        tbl[0]  = mk(1, 1, 0, 0,  1,  2, 1, 0);
        tbl[1]  = mk(1, 1, 0, 0,  3,  4, 0, 1);
        tbl[2]  = mk(1, 1, 1, 0,  5,  6, 1, 0);
        tbl[3]  = mk(1, 1, 0, 0,  7,  8, 0, 1);
        tbl[4]  = mk(1, 1, 0, 0,  9, 10, 1, 0);
        tbl[5]  = mk(1, 1, 0, 1, 11, 12, 0, 1);
        tbl[6]  = mk(1, 1, 0, 0, 13, 14, 1, 0);
        tbl[7]  = mk(1, 1, 0, 0, 15,  0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0,  1,  0, 1, 0);
        tbl[9]  = mk(1, 1, 0, 0,  2,  3, 0, 1);
        tbl[10] = mk(0, 0, 0, 0,  4,  5, 0, 0);
        tbl[11] = mk(1, 1, 0, 0,  6,  7, 1, 0);
        tbl[12] = mk(0, 1, 0, 0,  8,  9, 0, 1);
        tbl[13] = mk(1, 1, 0, 0, 10, 11, 1, 0);

        // Reset: outputs quiet even with both requesters asserting valid.
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        set_req(0, 1'b1, '0, '0, '0);
        set_req(1, 1'b1, '0, '0, '0);
        #1;
        reset_checks("rst");
        @(negedge clk);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        rst = 1'b0;
`ifdef URAM_ARB_ZEROIZE_EN
        zeroize_run();
`endif

        // Table: 8-cycle contention alternating from requester 0, then mixes.
        for (int i = 0; i < NTBL; i++) begin
            set_req(0, tbl[i].v0, tbl[i].we0, tbl[i].a0, rand_word());
            set_req(1, tbl[i].v1, tbl[i].we1, tbl[i].a1, rand_word());
            step();
            chk("tbl_rdy0", obs_r0, tbl[i].r0);
            chk("tbl_rdy1", obs_r1, tbl[i].r1);
        end
        idle(LAT + 1);

        // Single read: write via req0, read back via req1.
        set_req(0, 1'b1, {NC{1'b1}}, 5, 72'h0123456789ABCDEF01);
        step();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, '0, 5, rand_word());
        step();
        chk("single_rd_acc", obs_r1, 1'b1);
        idle(LAT + 1);
        chk("single_rd_data", last_rsp1, 72'h0123456789ABCDEF01);

        // Byte enables: only column 0 cleared.
        set_req(0, 1'b1, {NC{1'b1}}, 3, {DW{1'b1}});
        step();
        set_req(0, 1'b1, 9'h001, 3, '0);
        step();
        set_req(0, 1'b1, '0, 3, '0);
        step();
        idle(LAT + 1);
        chk("be_data", last_rsp0, 72'hFFFF_FFFF_FFFF_FFFF_00);

        // Interleaved: read A, write, read B back to back.
        seen0 = rsp_seen;
        set_req(0, 1'b1, '0, 10, '0);
        step();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 9'h0f0, 11, rand_word());
        step();
        set_req(1, 1'b0, '0, '0, '0);
        set_req(0, 1'b1, '0, 12, '0);
        step();
        idle(LAT + 2);
        chk("ilv_count", rsp_seen - seen0, 2);

`ifdef URAM_ARB_ZEROIZE_EN
        // Whole array cleared by the zeroize pass.
        set_req(1, 1'b1, '0, 9, '0);
        step();
        idle(LAT + 1);
        chk("zero_rd", last_rsp1, '0);
`endif

        // Reset two cycles after a read is accepted: its response is lost.
        set_req(0, 1'b1, '0, 7, '0);
        step();
        idle(2);
        rst = 1'b1;
        exp_q.delete();
        m_last = 1'b1;
        set_req(0, 1'b1, '0, 7, '0);
        set_req(1, 1'b1, '0, 8, '0);
        #1;
        reset_checks("mid");
        @(negedge clk);
        #1;
        reset_checks("mid2");
        @(negedge clk);
        cyc += 2;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        rst = 1'b0;
`ifdef URAM_ARB_ZEROIZE_EN
        zeroize_run();
`endif
        seen0 = rsp_seen;
        idle(LAT + 2);
        chk("mid_no_rsp", rsp_seen - seen0, 0);

        // Randomized traffic on a small address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            set_req(0, $urandom_range(0, 99) < 70,
                    ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0,
                    AW'($urandom_range(0, 15)), rand_word());
            set_req(1, $urandom_range(0, 99) < 70,
                    ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0,
                    AW'($urandom_range(0, 15)), rand_word());
            step();
        end
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uram_port_arbiter.md
# uram_port_arbiter

Round-robin controller that shares one single-port no-change UltraRAM between two requesters. It accepts read and write requests over valid/ready channels, drives the RAM port with at most one access per cycle, and tracks each read through the RAM's fixed pipeline latency. Each returned read word goes to the requester that issued it. It sits between the memory-mapped host/DMA agents and the UltraRAM instance in the platform memory subsystem.

## Interface

**Parameters**
- AWIDTH, 12, RAM address width.
- NUM_COL, 9, byte-enable columns.
- CWIDTH, 8, column width in bits.
- DWIDTH, 72, data width; must equal NUM_COL*CWIDTH.
- NBPIPE, 3, RAM output pipeline stages; read latency LAT = NBPIPE+2.

**Ports**
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- reqN_valid, input, 1, request valid (N = 0, 1).
- reqN_ready, output, 1, request accepted this cycle.
- reqN_we, input, NUM_COL, per-column write enable; all-zero means read.
- reqN_addr, input, AWIDTH, address.
- reqN_wdata, input, DWIDTH, write data.
- rspN_valid, output, 1, read data valid, single cycle, no backpressure.
- rspN_rdata, output, DWIDTH, read data.
- ram_mem_en, output, 1, RAM enable.
- ram_we, output, NUM_COL, RAM write enable.
- ram_addr, output, AWIDTH, RAM address.
- ram_din, output, DWIDTH, RAM write data.
- ram_regce, output, 1, tied to 1.
- ram_rst, output, 1, equals rst.
- ram_dout, input, DWIDTH, RAM read data.
- busy, output, 1, high while any read is in flight or zeroize is running.

## Operation

- **Arbitration**
  - Combinational grant between the requesters whose valid is high.
  - If only one requests, it wins.
  - If both request, the one not granted last wins. Register last_gnt updates only on an accepted transfer.
  - reqN_ready = grant to N while in state RUN. Transfer occurs when valid & ready.
- **RAM drive**
  - On a transfer: ram_mem_en=1; ram_addr, ram_we and ram_din come from the winner, all in the same cycle.
  - Otherwise: ram_mem_en=0, ram_we=0.
  - The RAM port is driven combinationally from the request; there is no request register.
- **Read tracking**
  - Tag shift register of LAT stages, each holding {valid, id}.
  - Stage 0 loads {transfer & ~|we, winner}; it advances every cycle.
  - When the last stage is valid: rsp[id]_valid=1 and rsp[id]_rdata=ram_dout.
  - Writes insert a bubble tag. They still pulse ram_mem_en, which moves stale data through the RAM pipeline; that data is ignored because its tag is invalid.
- **Back-to-back**: one access per cycle sustained, with any mix of reads and writes. Responses return in issue order.
- **States** (state register)
  - RUN: normal operation.
  - ZERO: present only with the macro; see Configuration.
- **Reset values**
  - All reqN_ready=0, rspN_valid=0, ram_mem_en=0, ram_we=0.
  - All tag stages invalid; last_gnt=1, so requester 0 wins the first tie; busy=0.
  - State is RUN, or ZERO with the macro.
- **Reset mid-operation**: in-flight reads are discarded and no response is issued for them.

## Timing

- Read latency: a read accepted at cycle t gives rspN_valid at cycle t+LAT (t+5 at the default NBPIPE=3).
- Write effect: visible to a read accepted at t+1 or later.
- Ready depends combinationally on valid within the same cycle. Requesters must not make valid depend on ready.
- A requester may drop valid without a transfer.
- rspN_rdata is undefined when rspN_valid=0.

## Configuration

- **URAM_ARB_ZEROIZE_EN defined**
  - After reset the block enters ZERO.
  - An AWIDTH-bit counter writes all-ones we and zero data to every address, one address per cycle, for 2^AWIDTH cycles.
  - Both reqN_ready are held at 0 and busy=1.
  - The block moves to RUN the cycle after the write to the last address. Counter wrap marks completion.
- **Not defined**: no ZERO state and no counter. Requests are accepted from the first cycle after reset deasserts.

## Structure

- **Package uram_arb_pkg**
  - LAT as the function NBPIPE+2.
  - The state enum {RUN, ZERO}.
  - The tag struct {valid, id}.
- **Sub-module uram_rd_tag_pipe**: parameterised LAT-deep {valid, id} shift register with asynchronous clear.
- The top level holds the arbiter, the RAM muxing, and the optional zeroize FSM.

## Test plan

- **Single read**: write 0x0123456789ABCDEF01 to address 5 via req0, then read address 5 via req1. Required: rsp1_valid exactly 5 cycles after acceptance with rdata 0x0123456789ABCDEF01, and rsp0_valid stays 0.
- **Contention**: both requesters hold valid for 8 cycles. Required: grants alternate 0,1,0,1,… starting with 0, and 8 transfers in 8 cycles.
- **Byte enables**: write all-ones to address 3, then write we=9'h001 with data 0 to address 3, then read. Required: 0xFFFF_FFFF_FFFF_FFFF_00.
- **Interleaved writes**: pattern read A, write, read B, accepted back-to-back. Required: exactly two responses, at t+5 and t+7, with the correct ids and data.
- **Reset mid-read**: assert rst 2 cycles after a read is accepted. Required: no rspN_valid occurs, and all outputs are at reset values while rst is high.
- **Zeroize (macro on, AWIDTH=4)**: ready stays 0 for 16 cycles after reset, then a read of any address returns 0.
